// File: rtl/btn_conditioner.sv
// btn_conditioner
//   Input-side front end for the game board. Each raw push-button is
//   synchronised, debounced and turned into a clean pressed level plus
//   single-cycle press, release and auto-repeat strobes. Channels are fully
//   independent; the only shared logic is the any_press OR.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst_n        synchronous active-low reset
//   btn_raw      asynchronous raw button pins (polarity set by ACTIVE_HIGH)
//   btn_level    debounced pressed state, 1 = pressed
//   btn_press    one-cycle strobe on an accepted press
//   btn_release  one-cycle strobe on an accepted release
//   btn_repeat   one-cycle auto-repeat strobe while held
//   any_press    OR of btn_press, registered alongside it
module btn_conditioner #(
  parameter int                N_BTN        = 5,
  parameter bit                ACTIVE_HIGH  = 1'b1,
  parameter int                DEBOUNCE_CYC = 20,
  parameter int                REPEAT_DELAY = 500,
  parameter int                REPEAT_RATE  = 100,
  parameter logic [N_BTN-1:0]  REPEAT_EN    = {N_BTN{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_press
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [9:0]    DEB_TERM  = 10'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] DLY_TERM  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_TERM = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RPT  = 2'd2
  } state_t;

  // Press decision of each channel for the coming edge; shared with any_press
  // so the OR lands in the same cycle as the individual strobes.
  logic [N_BTN-1:0] press_nxt;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [1:0]    sync_p0;
    logic [9:0]    dcnt;
    logic [RW-1:0] rcnt;
    state_t        state;
    logic          level, press, rel, rpt;
    logic          raw_in, s, accept, rel_nxt;

    assign raw_in = ACTIVE_HIGH ? btn_raw[i] : ~btn_raw[i];
    assign s      = sync_p0[1];

    // A level change is accepted once s has disagreed with the current
    // level for DEBOUNCE_CYC consecutive edges (including this one).
    assign accept       = (s != level) && (dcnt == DEB_TERM);
    assign press_nxt[i] = accept & s;
    assign rel_nxt      = accept & ~s;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync_p0 <= 2'b00;
        dcnt    <= 10'd0;
        level   <= 1'b0;
        press   <= 1'b0;
        rel     <= 1'b0;
        rpt     <= 1'b0;
        rcnt    <= '0;
        state   <= IDLE;
      end else begin
        // stage boundary: two-flop synchroniser
        sync_p0 <= {sync_p0[0], raw_in};

        press <= press_nxt[i];
        rel   <= rel_nxt;
        rpt   <= 1'b0;

        if (s == level) begin
          dcnt <= 10'd0;
        end else if (accept) begin
          dcnt  <= 10'd0;
          level <= s;
        end else begin
          dcnt <= dcnt + 10'd1;
        end

        // Release wins over any repeat that would fall on the same edge.
        if (rel_nxt) begin
          state <= IDLE;
          rcnt  <= '0;
        end else begin
          case (state)
            IDLE: begin
              rcnt <= '0;
              if (press_nxt[i] && REPEAT_EN[i]) state <= WAIT;
            end
            WAIT: begin
              if (rcnt == DLY_TERM) begin
                rpt   <= 1'b1;
                rcnt  <= '0;
                state <= RPT;
              end else begin
                rcnt <= rcnt + RW'(1);
              end
            end
            RPT: begin
              if (rcnt == RATE_TERM) begin
                rpt  <= 1'b1;
                rcnt <= '0;
              end else begin
                rcnt <= rcnt + RW'(1);
              end
            end
            default: begin
              state <= IDLE;
              rcnt  <= '0;
            end
          endcase
        end
      end
    end

    assign btn_level[i]   = level;
    assign btn_press[i]   = press;
    assign btn_release[i] = rel;
    assign btn_repeat[i]  = rpt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) any_press <= 1'b0;
    else        any_press <= |press_nxt;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner. Three instances share one clock and reset:
//   dut 0: active-high, repeat on all channels
//   dut 1: active-high, repeat mask 5'b11011 (same raw inputs as dut 0)
//   dut 2: active-low, repeat on all channels
// A behavioural model tracks each instance from the rules (stability window
// over the synchronised history, repeat slots as arithmetic on the press time)
// and is compared to every output on every falling edge.
module tb_btn_conditioner;

  localparam int DEB = 4;
  localparam int DLY = 10;
  localparam int RATE = 3;

  logic clk;
  logic rst_n;
  logic [4:0] raw;
  logic [4:0] raw_n;

  logic [2:0][4:0] lvl, prs, rel, rep;
  logic [2:0] anyp;

  btn_conditioner #(.N_BTN(5), .ACTIVE_HIGH(1'b1), .DEBOUNCE_CYC(DEB),
    .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .REPEAT_EN(5'b11111)) dut_a (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw), .btn_level(lvl[0]),
    .btn_press(prs[0]), .btn_release(rel[0]), .btn_repeat(rep[0]),
    .any_press(anyp[0]));

  btn_conditioner #(.N_BTN(5), .ACTIVE_HIGH(1'b1), .DEBOUNCE_CYC(DEB),
    .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .REPEAT_EN(5'b11011)) dut_m (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw), .btn_level(lvl[1]),
    .btn_press(prs[1]), .btn_release(rel[1]), .btn_repeat(rep[1]),
    .any_press(anyp[1]));

  btn_conditioner #(.N_BTN(5), .ACTIVE_HIGH(1'b0), .DEBOUNCE_CYC(DEB),
    .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .REPEAT_EN(5'b11111)) dut_n (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw_n), .btn_level(lvl[2]),
    .btn_press(prs[2]), .btn_release(rel[2]), .btn_repeat(rep[2]),
    .any_press(anyp[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int t = 0;
  bit cmp_en = 1'b0;

  // model state
  logic [2:0][4:0] m_lvl, m_prs, m_rel, m_rep, m_sy1, m_sy2, m_held;
  logic [2:0]      m_any;
  logic [31:0]     hist [3][5];
  int              pedge [3][5];
  logic [2:0][4:0] en_m;

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_lvl[d] = '0; m_prs[d] = '0; m_rel[d] = '0; m_rep[d] = '0;
      m_sy1[d] = '0; m_sy2[d] = '0; m_held[d] = '0; m_any[d] = 1'b0;
      for (int c = 0; c < 5; c++) begin
        hist[d][c] = '0;
        pedge[d][c] = 0;
      end
    end
  endtask

  task automatic model_step();
    logic [4:0] v;
    logic [31:0] mask;
    logic s;
    int age;
    mask = (32'd1 << DEB) - 32'd1;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int d = 0; d < 3; d++) begin
        v = (d == 2) ? ~raw_n : raw;
        for (int c = 0; c < 5; c++) begin
          s = m_sy2[d][c];
          hist[d][c] = {hist[d][c][30:0], s};
          m_prs[d][c] = 1'b0; m_rel[d][c] = 1'b0; m_rep[d][c] = 1'b0;
          if (!m_lvl[d][c] && ((hist[d][c] & mask) == mask)) begin
            m_lvl[d][c] = 1'b1;
            m_prs[d][c] = 1'b1;
            m_held[d][c] = 1'b1;
            pedge[d][c] = t;
          end else if (m_lvl[d][c] && ((hist[d][c] & mask) == 32'd0)) begin
            m_lvl[d][c] = 1'b0;
            m_rel[d][c] = 1'b1;
            m_held[d][c] = 1'b0;
          end else if (m_held[d][c] && en_m[d][c]) begin
            age = t - pedge[d][c];
            if (age >= DLY && ((age - DLY) % RATE) == 0) m_rep[d][c] = 1'b1;
          end
        end
        m_sy2[d] = m_sy1[d];
        m_sy1[d] = v;
        m_any[d] = |m_prs[d];
      end
    end
    t++;
  endtask

  task automatic cmp(input string nm, input int d, input logic [4:0] act,
                     input logic [4:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d edge %0d: got %b expected %b", nm, d, t - 1, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 3; d++) begin
        cmp("model_level", d, lvl[d], m_lvl[d]);
        cmp("model_press", d, prs[d], m_prs[d]);
        cmp("model_release", d, rel[d], m_rel[d]);
        cmp("model_repeat", d, rep[d], m_rep[d]);
        cmp("model_any", d, {4'b0, anyp[d]}, {4'b0, m_any[d]});
      end
    end
  end

  // one rising edge, model follows it, return at the next falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %b expected %b", nm, t - 1, act, exp);
    end
  endtask

  logic [8:0] pat;

  initial begin
    en_m[0] = 5'b11111; en_m[1] = 5'b11011; en_m[2] = 5'b11111;
    model_reset();
    rst_n = 1'b0;
    raw   = 5'b00000;
    raw_n = 5'b11111;
    @(negedge clk);
    tick();
    cmp_en = 1'b1;
    tick();
    chk("reset_level", lvl[0], 5'b00000);
    chk("reset_any", {4'b0, anyp[0]}, 5'b00000);
    rst_n = 1'b1;
    repeat (3) tick();

    // clean press/release on channel 0
    raw[0] = 1'b1;
    repeat (5) tick();
    chk("t1_no_press_early", {4'b0, prs[0][0]}, 5'd0);
    tick();
    chk("t1_press", {4'b0, prs[0][0]}, 5'd1);
    chk("t1_any", {4'b0, anyp[0]}, 5'd1);
    chk("t1_level", {4'b0, lvl[0][0]}, 5'd1);
    tick();
    chk("t1_press_one_cycle", {4'b0, prs[0][0]}, 5'd0);
    chk("t1_level_held", {4'b0, lvl[0][0]}, 5'd1);
    repeat (22) tick();
    raw[0] = 1'b0;
    repeat (5) tick();
    chk("t1_no_release_early", {4'b0, rel[0][0]}, 5'd0);
    tick();
    chk("t1_release", {4'b0, rel[0][0]}, 5'd1);
    chk("t1_level_low", {4'b0, lvl[0][0]}, 5'd0);
    repeat (4) tick();

    // bounce rejection on channel 1
    pat = 9'b111101101;
    for (int i = 0; i < 9; i++) begin
      raw[1] = pat[i];
      tick();
      chk("t2_no_press_bounce", {4'b0, prs[0][1]}, 5'd0);
    end
    tick();
    chk("t2_no_press_e9", {4'b0, prs[0][1]}, 5'd0);
    tick();
    chk("t2_press", {4'b0, prs[0][1]}, 5'd1);
    raw[1] = 1'b0;
    repeat (8) tick();

    // auto-repeat on channel 2 (dut 0) and masked channel 2 (dut 1)
    raw[2] = 1'b1;
    repeat (6) tick();
    chk("t3_press", {4'b0, prs[0][2]}, 5'd1);
    chk("t4_press_masked", {4'b0, prs[1][2]}, 5'd1);
    repeat (9) tick();
    chk("t3_no_rep_p9", {4'b0, rep[0][2]}, 5'd0);
    tick();
    chk("t3_rep_p10", {4'b0, rep[0][2]}, 5'd1);
    chk("t4_no_rep_masked", {4'b0, rep[1][2]}, 5'd0);
    tick();
    chk("t3_rep_p11_low", {4'b0, rep[0][2]}, 5'd0);
    repeat (2) tick();
    chk("t3_rep_p13", {4'b0, rep[0][2]}, 5'd1);
    repeat (18) tick();
    raw[2] = 1'b0;
    repeat (3) tick();
    chk("t3_rep_p34", {4'b0, rep[0][2]}, 5'd1);
    repeat (3) tick();
    chk("t3_release", {4'b0, rel[0][2]}, 5'd1);
    chk("t3_no_rep_on_release", {4'b0, rep[0][2]}, 5'd0);
    chk("t4_release_masked", {4'b0, rel[1][2]}, 5'd1);
    repeat (6) tick();

    // reset during WAIT with channel 2 held
    raw[2] = 1'b1;
    repeat (6) tick();
    chk("t5_press", {4'b0, prs[0][2]}, 5'd1);
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    for (int d = 0; d < 3; d++) begin
      chk("t5_rst_level", lvl[d], 5'd0);
      chk("t5_rst_press", prs[d], 5'd0);
      chk("t5_rst_release", rel[d], 5'd0);
      chk("t5_rst_repeat", rep[d], 5'd0);
      chk("t5_rst_any", {4'b0, anyp[d]}, 5'd0);
    end
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t5_no_press_early", {4'b0, prs[0][2]}, 5'd0);
    tick();
    chk("t5_repress", {4'b0, prs[0][2]}, 5'd1);
    repeat (10) tick();
    chk("t5_first_rep", {4'b0, rep[0][2]}, 5'd1);
    raw[2] = 1'b0;
    repeat (10) tick();

    // simultaneous presses, active-low instance
    raw_n = 5'b00110;
    repeat (5) tick();
    chk("t6_no_press_early", prs[2], 5'b00000);
    tick();
    chk("t6_press", prs[2], 5'b11001);
    chk("t6_any", {4'b0, anyp[2]}, 5'd1);
    chk("t6_level", lvl[2], 5'b11001);
    tick();
    chk("t6_any_one_cycle", {4'b0, anyp[2]}, 5'd0);
    raw_n = 5'b11111;
    repeat (10) tick();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Input-side front end for the game board: takes the five raw push-buttons (start, shift, tens/units time-set, set) and turns them into clean, synchronised, debounced levels plus single-cycle press, release and auto-repeat strobes. It is the counterpart of the display/LED/beeper output path. It sits between the board pins and the game control logic. The control logic consumes only this block's strobes, never raw buttons.

## Interface
Parameters:
- `N_BTN`, 5, number of button channels.
- `ACTIVE_HIGH`, 1, raw polarity: 1 means a pressed button reads 1; 0 means pressed reads 0.
- `DEBOUNCE_CYC`, 20, consecutive stable cycles required to accept a level change. Legal range 1..1023. Default is 20 ms at 1 kHz.
- `REPEAT_DELAY`, 500, cycles from the press strobe to the first repeat strobe. Must be ≥1.
- `REPEAT_RATE`, 100, cycles between subsequent repeat strobes. Must be ≥1.
- `REPEAT_EN`, {N_BTN{1'b1}}, per-channel auto-repeat enable mask.

Ports:
- `clk`, input, 1: system clock (1 kHz board clock). All logic is on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `btn_raw`, input, N_BTN: asynchronous raw button pins.
- `btn_level`, output, N_BTN: debounced pressed state; 1 = pressed, independent of polarity.
- `btn_press`, output, N_BTN: one-cycle strobe on an accepted press.
- `btn_release`, output, N_BTN: one-cycle strobe on an accepted release.
- `btn_repeat`, output, N_BTN: one-cycle auto-repeat strobe while held.
- `any_press`, output, 1: OR of `btn_press`, registered in the same cycle as `btn_press`.

## Operation
- Each channel is independent and identical. Channels share no state except the `any_press` OR.
- Synchroniser: a 2-flop chain per channel. If ACTIVE_HIGH=0 the input is inverted before the chain. The chain output is `s`.
- Debounce: the counter `dcnt` (10 bits) clears whenever `s == btn_level`. Otherwise it increments each cycle.
  - When `s != btn_level` and `dcnt == DEBOUNCE_CYC-1`, `btn_level` takes `s` on that edge and `dcnt` clears.
  - A single-cycle glitch shorter than DEBOUNCE_CYC never changes `btn_level`.
- Strobes are registered with the `btn_level` update:
  - `btn_press` is high for the single cycle after a 0→1 transition of `btn_level`.
  - `btn_release` is high for the single cycle after a 1→0 transition.
- Per-channel repeat FSM (only when `REPEAT_EN[i]`=1; otherwise the channel stays in IDLE and `btn_repeat[i]` is constant 0):
  - IDLE → WAIT on accepted press. `rcnt` clears.
  - In WAIT, `rcnt` increments each cycle. When `rcnt == REPEAT_DELAY-1`, `btn_repeat` pulses, `rcnt` clears and the FSM goes to RPT.
  - In RPT, `rcnt` increments. When `rcnt == REPEAT_RATE-1`, `btn_repeat` pulses and `rcnt` clears. The FSM stays in RPT.
  - WAIT/RPT → IDLE on accepted release, on the same edge. No repeat strobe occurs on or after that edge.
- `btn_repeat` never coincides with `btn_press` for the same channel.
- Counter widths:
  - `rcnt` is `$clog2(max(REPEAT_DELAY,REPEAT_RATE))` bits, minimum 1.
  - Counters never wrap in legal operation, because each clears on its terminal compare.

## Timing
- Reset state (`rst_n`=0 sampled on an edge):
  - Synchronisers 0, `btn_level` 0, all strobes 0, `any_press` 0, counters 0, FSM IDLE.
- Reset mid-debounce or mid-repeat aborts the operation with no strobe.
- A button held through reset produces a press strobe DEBOUNCE_CYC+2 cycles after `rst_n` rises. This is treated as a new press.
- Press latency: raw goes pressed and is first sampled at edge k and stays stable. Then `btn_level` rises and `btn_press` is high during the cycle after edge k+1+DEBOUNCE_CYC.
- Release latency is identical.
- The first repeat strobe comes REPEAT_DELAY cycles after the press strobe. Later strobes are spaced REPEAT_RATE cycles apart.
- Simultaneous presses on several channels produce same-cycle strobes on each channel and a single-cycle `any_press`.

## Test plan
Bench parameters: N_BTN=5, DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_RATE=3.
1. Clean press/release: `btn_raw[0]` goes 0→1 at edge 0 and is held 30 cycles, then released. Required: `btn_press[0]` and `any_press` high only in the cycle after edge 5, and `btn_level[0]` is 1 from there. `btn_release[0]` is high in the cycle 5 edges after release sampling.
2. Bounce rejection: `btn_raw[1]` toggles 1,0,1,1,0,1,1,1,1 on successive edges. Required: no strobe until the 4-cycle stable run, then exactly one `btn_press[1]`. The glitches (runs of 3 or fewer) produce nothing.
3. Auto-repeat: hold `btn_raw[2]` for 30 cycles after press acceptance at cycle P. Required: `btn_repeat[2]` at P+10, P+13, P+16, …. It stops at the accepted release, with no repeat on the release cycle.
4. Repeat mask: set `REPEAT_EN`=5'b11011 and hold channel 2 for 30 cycles. Required: `btn_repeat[2]` stays 0, while press and release strobes behave normally.
5. Reset mid-hold: assert `rst_n`=0 at P+7 during WAIT with the button still held, then release reset. Required: all outputs are 0 during reset. A new `btn_press` appears 6 cycles after `rst_n` rises, and the first repeat strobe comes 10 cycles after that.
6. Simultaneous / inverted polarity: with ACTIVE_HIGH=0, drive `btn_raw` 11111→00110 at edge 0. Required: `btn_press`=5'b11001 in the cycle after edge 5, and `any_press` high for exactly that one cycle.
